// File: rtl/dispense_demux_4_pkg.sv
// Shared definitions for the dispense demux and the vending controller:
// FSM state encoding, default timing, status bundle and channel decode.
package dispense_demux_4_pkg;

    localparam int unsigned DEF_PULSE_LEN = 8;
    localparam int unsigned DEF_GAP_LEN   = 4;
    localparam int unsigned DEF_CNT_W     = 8;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_PULSE = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;

    typedef struct packed {
        logic ack;
        logic busy;
        logic done;
        logic aborted;
    } status_t;

    // Channel index {S2,S1} to one-hot motor drive, bit n = channel n.
    function automatic logic [3:0] onehot4(input logic [1:0] idx);
        onehot4 = 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/dispense_demux_4_timer.sv
// dispense_timer: loadable down-counter that parks at zero; terminal-count
// flag is high whenever the count is zero.
module dispense_timer #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    output logic             o_tc_c
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - CNT_W'(1);
        end
    end

    assign o_tc_c = (r_count == '0);

endmodule

// File: rtl/dispense_demux_4.sv
// Four-channel dispense pulse generator: captures a request and channel,
// drives one motor for PULSE_LEN cycles, settles for GAP_LEN cycles.
module dispense_demux_4
    import dispense_demux_4_pkg::*;
#(
    parameter int unsigned PULSE_LEN = DEF_PULSE_LEN,
    parameter int unsigned GAP_LEN   = DEF_GAP_LEN,
    parameter int unsigned CNT_W     = DEF_CNT_W
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req,
    input  logic [1:0] sel,
    input  logic       abort,
    output logic [3:0] motor,
    output logic       ack,
    output logic       busy,
    output logic       done,
    output logic       aborted
);

    localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_LEN - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD   = (GAP_LEN == 0) ? '0 : CNT_W'(GAP_LEN - 1);

    logic [1:0]       r_state;
    logic [1:0]       r_sel;
    logic [3:0]       r_motor;
    status_t          r_status;

    logic [1:0]       w_state_nxt;
    logic [1:0]       w_sel_nxt;
    logic [3:0]       w_motor_nxt;
    status_t          w_status_nxt;
    logic             w_load;
    logic [CNT_W-1:0] w_load_val;
    logic             w_tc;

    dispense_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .o_tc_c     (w_tc)
    );

    // Next state and next registered outputs; abort outranks every other move.
    always_comb begin
        w_state_nxt  = r_state;
        w_sel_nxt    = r_sel;
        w_motor_nxt  = '0;
        w_status_nxt = '0;
        w_load       = 1'b0;
        w_load_val   = '0;
        case (r_state)
            ST_IDLE: begin
                if (req && !abort) begin
                    w_state_nxt          = ST_PULSE;
                    w_sel_nxt            = sel;
                    w_load               = 1'b1;
                    w_load_val           = PULSE_LOAD;
                    w_motor_nxt          = onehot4(sel);
                    w_status_nxt.ack     = 1'b1;
                    w_status_nxt.busy    = 1'b1;
                end
            end
            ST_PULSE: begin
                if (abort) begin
                    w_state_nxt          = ST_IDLE;
                    w_status_nxt.aborted = 1'b1;
                end else if (w_tc) begin
                    if (GAP_LEN == 0) begin
                        w_state_nxt       = ST_IDLE;
                        w_status_nxt.done = 1'b1;
                    end else begin
                        w_state_nxt       = ST_GAP;
                        w_load            = 1'b1;
                        w_load_val        = GAP_LOAD;
                        w_status_nxt.busy = 1'b1;
                    end
                end else begin
                    w_motor_nxt       = onehot4(r_sel);
                    w_status_nxt.busy = 1'b1;
                end
            end
            ST_GAP: begin
                if (abort) begin
                    w_state_nxt          = ST_IDLE;
                    w_status_nxt.aborted = 1'b1;
                end else if (w_tc) begin
                    w_state_nxt       = ST_IDLE;
                    w_status_nxt.done = 1'b1;
                end else begin
                    w_status_nxt.busy = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_sel    <= '0;
            r_motor  <= '0;
            r_status <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_sel    <= w_sel_nxt;
            r_motor  <= w_motor_nxt;
            r_status <= w_status_nxt;
        end
    end

    assign motor   = r_motor;
    assign ack     = r_status.ack;
    assign busy    = r_status.busy;
    assign done    = r_status.done;
    assign aborted = r_status.aborted;

endmodule

// File: tb/tb_dispense_demux_4.sv
// Bench for dispense_demux_4: default build (8/4) and a GAP_LEN=0 build share
// stimulus; each is compared every cycle against a dispense-schedule model.
module tb_dispense_demux_4;

    localparam int unsigned P = 8;

    logic       clk;
    logic       tb_rst_n;
    logic       tb_req;
    logic [1:0] tb_sel;
    logic       tb_abort;

    logic [3:0] motor4, motor0;
    logic       ack4, busy4, done4, aborted4;
    logic       ack0, busy0, done0, aborted0;

    int total = 0;
    int bad   = 0;
    int step_no = 0;

    dispense_demux_4 #(.PULSE_LEN(8), .GAP_LEN(4), .CNT_W(8)) dut (
        .clk(clk), .rst_n(tb_rst_n), .req(tb_req), .sel(tb_sel), .abort(tb_abort),
        .motor(motor4), .ack(ack4), .busy(busy4), .done(done4), .aborted(aborted4)
    );

    dispense_demux_4 #(.PULSE_LEN(8), .GAP_LEN(0), .CNT_W(8)) dut0 (
        .clk(clk), .rst_n(tb_rst_n), .req(tb_req), .sel(tb_sel), .abort(tb_abort),
        .motor(motor0), .ack(ack0), .busy(busy0), .done(done0), .aborted(aborted0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: a dispense is an age count since capture; motor while age < P,
    // busy until age reaches P+gap, which is the done cycle.
    logic       m_act[2] = '{1'b0, 1'b0};
    int         m_age[2] = '{0, 0};
    logic [1:0] m_ch[2]  = '{2'd0, 2'd0};
    logic [7:0] m_exp[2] = '{8'h00, 8'h00};

    always @(posedge clk) begin
        for (int m = 0; m < 2; m++) begin
            int glen;
            glen = (m == 0) ? 4 : 0;
            if (!tb_rst_n) begin
                m_act[m] = 1'b0;
                m_exp[m] = 8'h00;
            end else if (m_act[m]) begin
                if (tb_abort) begin
                    m_act[m] = 1'b0;
                    m_exp[m] = 8'b0000_0001;
                end else begin
                    m_age[m] = m_age[m] + 1;
                    if (m_age[m] == P + glen) begin
                        m_act[m] = 1'b0;
                        m_exp[m] = 8'b0000_0010;
                    end else begin
                        m_exp[m] = {((m_age[m] < P) ? (4'b0001 << m_ch[m]) : 4'b0000), 4'b0100};
                    end
                end
            end else if (tb_req && !tb_abort) begin
                m_act[m] = 1'b1;
                m_age[m] = 0;
                m_ch[m]  = tb_sel;
                m_exp[m] = {4'b0001 << tb_sel, 4'b1100};
            end else begin
                m_exp[m] = 8'h00;
            end
        end
    end

    function automatic logic [7:0] got4();
        return {motor4, ack4, busy4, done4, aborted4};
    endfunction

    function automatic logic [7:0] got0();
        return {motor0, ack0, busy0, done0, aborted0};
    endfunction

    task automatic chk(input string name, input logic [7:0] g, input logic [7:0] w);
        total++;
        if (g !== w) begin
            bad++;
            $display("FAIL %s step=%0d got=%b want=%b", name, step_no, g, w);
        end
    endtask

    // Apply one cycle of inputs, then check both builds against the model.
    task automatic step(input logic r, input logic [1:0] s, input logic a, input logic rn);
        tb_req = r; tb_sel = s; tb_abort = a; tb_rst_n = rn;
        @(negedge clk);
        step_no++;
        chk("model_g4", got4(), m_exp[0]);
        chk("model_g0", got0(), m_exp[1]);
        chk("onehot_g4", 8'($countones(motor4) <= 1), 8'd1);
        chk("onehot_g0", 8'($countones(motor0) <= 1), 8'd1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 2'd0, 1'b0, 1'b1);
    endtask

    typedef struct {
        logic       req;
        logic [1:0] sel;
        logic       abort;
        logic       rst_n;
        logic [7:0] exp;
    } vec_t;

    vec_t tbl[16];

    initial begin
        // Reset, one request on channel c, sel/req noise while busy, done.
        tbl[0] = '{1'b0, 2'd0, 1'b0, 1'b0, 8'h00};
        tbl[1] = '{1'b0, 2'd0, 1'b0, 1'b1, 8'h00};
        tbl[2] = '{1'b1, 2'd2, 1'b0, 1'b1, {4'b0100, 4'b1100}};
        for (int i = 3; i <= 9; i++)   tbl[i] = '{1'b0, 2'd3, 1'b0, 1'b1, {4'b0100, 4'b0100}};
        for (int i = 10; i <= 13; i++) tbl[i] = '{1'b1, 2'd1, 1'b0, 1'b1, 8'b0000_0100};
        tbl[14] = '{1'b0, 2'd0, 1'b0, 1'b1, 8'b0000_0010};
        tbl[15] = '{1'b0, 2'd0, 1'b0, 1'b1, 8'h00};

        tb_req = 1'b0; tb_sel = 2'd0; tb_abort = 1'b0; tb_rst_n = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 16; i++) begin
            step(tbl[i].req, tbl[i].sel, tbl[i].abort, tbl[i].rst_n);
            chk("table", got4(), tbl[i].exp);
        end

        // Continuous request: g4 re-acks every 13 cycles, g0 every 9.
        idle(14);
        for (int i = 0; i < 30; i++) begin
            step(1'b1, 2'd1, 1'b0, 1'b1);
            chk("b2b_ack_g4", 8'(ack4), 8'((i % 13) == 0));
            chk("b2b_ack_g0", 8'(ack0), 8'((i % 9) == 0));
        end

        // Channel d captured; sel churns during the pulse.
        idle(14);
        step(1'b1, 2'd3, 1'b0, 1'b1);
        chk("sel_hold", 8'(motor4), 8'b0000_1000);
        for (int i = 1; i < 8; i++) begin
            step(1'b0, 2'(i), 1'b0, 1'b1);
            chk("sel_hold", 8'(motor4), 8'b0000_1000);
        end

        // Abort during the fifth pulse cycle.
        idle(14);
        step(1'b1, 2'd0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b0, 2'd0, 1'b0, 1'b1);
        step(1'b0, 2'd0, 1'b1, 1'b1);
        chk("abort_g4", got4(), 8'b0000_0001);
        chk("abort_g0", got0(), 8'b0000_0001);
        for (int i = 0; i < 14; i++) begin
            step(1'b0, 2'd0, 1'b0, 1'b1);
            chk("abort_no_done", 8'(done4), 8'd0);
        end

        // Abort and request together in idle: nothing happens.
        step(1'b1, 2'd2, 1'b1, 1'b1);
        chk("abort_wins", got4(), 8'h00);

        // Reset during gap, then a fresh dispense.
        idle(14);
        step(1'b1, 2'd1, 1'b0, 1'b1);
        for (int i = 0; i < 9; i++) step(1'b0, 2'd0, 1'b0, 1'b1);
        chk("in_gap", got4(), 8'b0000_0100);
        step(1'b1, 2'd3, 1'b0, 1'b0);
        chk("rst_gap", got4(), 8'h00);
        for (int i = 0; i < 14; i++) begin
            step(1'b0, 2'd0, 1'b0, 1'b1);
            chk("rst_quiet", 8'({done4, aborted4}), 8'd0);
        end
        step(1'b1, 2'd2, 1'b0, 1'b1);
        chk("post_rst_ack", got4(), {4'b0100, 4'b1100});
        for (int i = 0; i < 11; i++) step(1'b0, 2'd0, 1'b0, 1'b1);
        step(1'b0, 2'd0, 1'b0, 1'b1);
        chk("post_rst_done", got4(), 8'b0000_0010);

        // Random traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                 1'($urandom_range(0, 31) == 0), 1'($urandom_range(0, 127) != 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dispense_demux_4.md
DISPENSE_DEMUX_4 -- requirements
Module: dispense_demux_4

Interface
REQ-001 SHALL have parameter PULSE_LEN, default 8, motor-on duration in clk cycles (legal 1..255).
REQ-002 SHALL have parameter GAP_LEN, default 4, post-pulse settle duration in clk cycles (legal 0..255).
REQ-003 SHALL have parameter CNT_W, default 8, width of the internal duration counter.
REQ-004 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port req  input  1  dispense request, level-sampled each edge.
REQ-007 SHALL have port sel  input  2  channel index {S2,S1}: 0=a, 1=b, 2=c, 3=d, same code as the 4:1 select path.
REQ-008 SHALL have port abort  input  1  coin-return/fault abort.
REQ-009 SHALL have port motor  output  4  one-hot dispense drive, bit n = channel n.
REQ-010 SHALL have port ack  output  1  one-cycle pulse: request captured.
REQ-011 SHALL have port busy  output  1  high while a dispense is in progress.
REQ-012 SHALL have port done  output  1  one-cycle pulse: dispense completed normally.
REQ-013 SHALL have port aborted  output  1  one-cycle pulse: dispense terminated by abort.

Function
REQ-014 SHALL implement FSM states IDLE, PULSE, GAP; all outputs registered.
REQ-015 In IDLE with req=1 and abort=0 at edge k, SHALL latch sel, go to PULSE, and drive ack=1 and busy=1 in cycle k+1.
REQ-016 SHALL drive motor = one-hot(latched sel) for exactly PULSE_LEN cycles, k+1..k+PULSE_LEN; all other motor bits 0.
REQ-017 After PULSE, SHALL hold motor=0, busy=1 in GAP for GAP_LEN cycles; GAP_LEN=0 SHALL skip GAP entirely.
REQ-018 SHALL return to IDLE in cycle k+PULSE_LEN+GAP_LEN+1 with busy=0 and done=1 for that one cycle.
REQ-019 req in the done cycle SHALL be accepted (back-to-back dispense, no dead cycle).
REQ-020 req while busy=1 SHALL be ignored, not queued; sel changes after capture SHALL not affect motor.
REQ-021 abort=1 at any edge in PULSE or GAP SHALL force motor=0, busy=0, state IDLE next cycle, with aborted=1 there and done=0.
REQ-022 abort=1 and req=1 together in IDLE SHALL not start a dispense (abort wins; no ack, no aborted).
REQ-023 motor SHALL never have more than one bit set in any cycle.
REQ-024 Counter SHALL be a CNT_W-bit down-counter loaded with length-1 on state entry; no wrap-around reachable.

Reset
REQ-025 rst_n=0 at an edge SHALL give next cycle: state IDLE, motor=0000, ack=busy=done=aborted=0, counter=0, latched sel=0.
REQ-026 Reset mid-PULSE or mid-GAP SHALL kill motor in the next cycle and SHALL NOT emit done or aborted.
REQ-027 req sampled while rst_n=0 SHALL be discarded.

Structure
REQ-028 Shared package SHALL hold FSM state encoding (IDLE=0, PULSE=1, GAP=2) and the PULSE_LEN/GAP_LEN defaults, shared with the vending controller.
REQ-029 One sub-module SHALL be natural: dispense_timer (loadable CNT_W down-counter with terminal-count flag); one-hot decode stays inline.

Verification (PULSE_LEN=8, GAP_LEN=4)
REQ-030 req=1, sel=2 one cycle at edge 10 -> ack @11; motor=0100 @11..18; motor=0 busy=1 @19..22; done=1 busy=0 @23.
REQ-031 req held high continuously, sel=1 -> ack @11 and @24; motor=0010 @11..18 and @24..31; no extra ack in between.
REQ-032 sel=3 dispense started, sel toggled 0..3 during PULSE -> motor stays 1000 for all 8 cycles.
REQ-033 abort=1 at 5th PULSE cycle -> motor=0, aborted=1, busy=0 next cycle; done never asserted.
REQ-034 rst_n=0 for 1 cycle during GAP -> all outputs 0 next cycle; done/aborted never asserted; new req after reset behaves as REQ-030.
REQ-035 GAP_LEN=0 build, req sel=0 -> motor=0001 @11..18, done @19, back-to-back req accepted at 19.
